// File: rtl/pipeline_controller_n.sv
// pipeline_controller_n: parametrised per-stage stall/clear controller with a
// post-flush refetch penalty and an interrupt drain/grant FSM.
module pipeline_controller_n #(
    parameter int NUM_STAGES    = 10,
    parameter int FLUSH_PENALTY = 2,
    parameter int EMPTY_HOLD    = 3,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallUpperReq,
    input  logic [NUM_STAGES-1:0] flushUpperReq,
    input  logic [NUM_STAGES-1:0] sendBubbleLowerReq,
    input  logic [NUM_STAGES-1:0] stageEmpty,
    input  logic                  activeListEmpty,
    input  logic                  interruptReq,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] clear,
    output logic                  wholePipelineEmpty,
    output logic                  interruptBubble,
    output logic                  interruptGrant,
    output logic                  penaltyActive
);
    typedef enum logic [1:0] {IDLE, DRAIN, GRANT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  pen_q, pen_d, emp_q, emp_d;
    logic                  bubble_q, bubble_d, grant_q, grant_d;
    logic [NUM_STAGES-1:0] stall_any, flush_any;
    logic                  drained;

    assign wholePipelineEmpty = &stageEmpty & activeListEmpty;
    assign interruptBubble    = bubble_q;
    assign interruptGrant     = grant_q;
    assign penaltyActive      = pen_q != '0;

    // A request at stage j reaches every stage in front of it; flush beats stall.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stall_any[k] = |(stallUpperReq >> k);
            flush_any[k] = |(flushUpperReq >> k);
        end
        stall    = stall_any & ~flush_any;
        stall[0] = stall[0] | (penaltyActive & ~flush_any[0]);
        clear    = flush_any | stallUpperReq | sendBubbleLowerReq;
        clear[0] = clear[0] | interruptBubble;
    end

    always_comb begin
        pen_d    = flushUpperReq[NUM_STAGES-1] ? CNT_WIDTH'(FLUSH_PENALTY)
                 : penaltyActive ? pen_q - CNT_WIDTH'(1) : pen_q;
        emp_d    = (wholePipelineEmpty && state_q == DRAIN)
                 ? (emp_q == CNT_WIDTH'(EMPTY_HOLD) ? emp_q : emp_q + CNT_WIDTH'(1)) : '0;
        drained  = wholePipelineEmpty && emp_q >= CNT_WIDTH'(EMPTY_HOLD - 1);
        state_d  = state_q == IDLE  ? (interruptReq ? DRAIN : IDLE)
                 : state_q == DRAIN ? (!interruptReq ? IDLE : drained ? GRANT : DRAIN)
                 : state_q == GRANT ? HOLD
                 : (interruptReq ? HOLD : IDLE);
        bubble_d = state_d != IDLE;
        grant_d  = state_d == GRANT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pen_q    <= '0;
            emp_q    <= '0;
            bubble_q <= 1'b0;
            grant_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pen_q    <= pen_d;
            emp_q    <= emp_d;
            bubble_q <= bubble_d;
            grant_q  <= grant_d;
        end
    end
endmodule

// File: tb/tb_pipeline_controller_n.sv
// tb_pipeline_controller_n: scoreboard bench for the stall/clear network,
// flush penalty, interrupt drain FSM and asynchronous reset.
module tb_pipeline_controller_n;
    logic       clk, rst;
    logic [9:0] stallUpperReq, flushUpperReq, sendBubbleLowerReq, stageEmpty;
    logic       activeListEmpty, interruptReq;
    logic [9:0] stall, clear;
    logic       wholePipelineEmpty, interruptBubble, interruptGrant, penaltyActive;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] su, fu, sb, se;
        logic       ale, ir;
        logic [9:0] st, cl;
        logic       wpe, bub, gnt, pen;
    } step_t;
    typedef struct {
        string       name;
        logic [23:0] v;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [9:0] Z = 10'h000, F = 10'h3FF;
    localparam logic O = 1'b0, I = 1'b1;

    pipeline_controller_n #(
        .NUM_STAGES(10), .FLUSH_PENALTY(2), .EMPTY_HOLD(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .stallUpperReq(stallUpperReq), .flushUpperReq(flushUpperReq),
        .sendBubbleLowerReq(sendBubbleLowerReq), .stageEmpty(stageEmpty),
        .activeListEmpty(activeListEmpty), .interruptReq(interruptReq),
        .stall(stall), .clear(clear), .wholePipelineEmpty(wholePipelineEmpty),
        .interruptBubble(interruptBubble), .interruptGrant(interruptGrant),
        .penaltyActive(penaltyActive)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply(input step_t s);
        stallUpperReq      = s.su;
        flushUpperReq      = s.fu;
        sendBubbleLowerReq = s.sb;
        stageEmpty         = s.se;
        activeListEmpty    = s.ale;
        interruptReq       = s.ir;
    endtask

    function automatic logic [23:0] expect_of(input step_t s);
        return {s.st, s.cl, s.wpe, s.bub, s.gnt, s.pen};
    endfunction

    function automatic logic [23:0] observed();
        return {stall, clear, wholePipelineEmpty, interruptBubble, interruptGrant, penaltyActive};
    endfunction

    task automatic test_reset();
        step_t t[$];
        exp_t  e;
        t.push_back('{10'h008, Z, Z, Z, O, O, 10'h00F, 10'h008, O, O, O, O});
        t.push_back('{Z, 10'h200, Z, Z, O, O, Z, F, O, O, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, Z, I, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("reset[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        @(posedge clk); #1;
        apply('{Z, Z, Z, Z, O, O, Z, Z, O, O, O, O});
        rst = 1'b1;
    endtask

    task automatic test_comb();
        step_t t[$];
        exp_t  e;
        t.push_back('{10'h008, Z, Z, Z, O, O, 10'h00F, 10'h008, O, O, O, O});
        t.push_back('{10'h008, 10'h020, Z, Z, O, O, Z, 10'h03F, O, O, O, O});
        t.push_back('{Z, Z, 10'h011, Z, O, O, Z, 10'h011, O, O, O, O});
        t.push_back('{10'h200, Z, Z, Z, O, O, F, 10'h200, O, O, O, O});
        t.push_back('{10'h004, 10'h004, Z, Z, O, O, Z, 10'h007, O, O, O, O});
        t.push_back('{10'h100, 10'h002, 10'h040, Z, O, O, 10'h1FC, 10'h143, O, O, O, O});
        t.push_back('{Z, Z, Z, F, O, O, Z, Z, O, O, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, Z, I, O, O, O});
        t.push_back('{Z, Z, Z, 10'h3EF, I, O, Z, Z, O, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("comb[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_penalty();
        step_t t[$];
        exp_t  e;
        t.push_back('{Z, 10'h200, Z, Z, O, O, Z, F, O, O, O, O});
        t.push_back('{Z, Z, Z, Z, O, O, 10'h001, Z, O, O, O, I});
        t.push_back('{Z, Z, Z, Z, O, O, 10'h001, Z, O, O, O, I});
        t.push_back('{Z, Z, Z, Z, O, O, Z, Z, O, O, O, O});
        t.push_back('{Z, 10'h200, Z, Z, O, O, Z, F, O, O, O, O});
        t.push_back('{Z, Z, Z, Z, O, O, 10'h001, Z, O, O, O, I});
        t.push_back('{Z, 10'h200, Z, Z, O, O, Z, F, O, O, O, I});
        t.push_back('{Z, Z, Z, Z, O, O, 10'h001, Z, O, O, O, I});
        t.push_back('{10'h004, Z, Z, Z, O, O, 10'h007, 10'h004, O, O, O, I});
        t.push_back('{Z, Z, Z, Z, O, O, Z, Z, O, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("penalty[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_interrupt();
        step_t t[$];
        exp_t  e;
        t.push_back('{Z, Z, Z, Z, O, I, Z, Z, O, O, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, I, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, Z, I, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("interrupt[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_abort();
        step_t t[$];
        exp_t  e;
        t.push_back('{Z, Z, Z, Z, O, I, Z, Z, O, O, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, Z, I, O, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, Z, I, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("abort[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_drain_break();
        step_t t[$];
        exp_t  e;
        t.push_back('{Z, Z, Z, F, I, I, Z, Z, I, O, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, 10'h3EF, I, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, 10'h020, Z, F, I, I, Z, 10'h03F, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, I, Z, 10'h001, I, I, I, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, 10'h001, I, I, O, O});
        t.push_back('{Z, Z, Z, F, I, O, Z, Z, I, O, O, O});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("drain_break[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        step_t t[$];
        exp_t  e;
        t.push_back('{Z, 10'h200, Z, Z, O, I, Z, F, O, O, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, 10'h001, 10'h001, O, I, O, I});
        t.push_back('{Z, Z, Z, Z, O, I, 10'h001, 10'h001, O, I, O, I});
        t.push_back('{Z, Z, Z, Z, O, I, Z, 10'h001, O, I, O, O});
        t.push_back('{Z, 10'h200, Z, Z, O, I, Z, F, O, I, O, O});
        t.push_back('{Z, Z, Z, Z, O, I, 10'h001, 10'h001, O, I, O, I});
        foreach (t[i]) begin
            @(posedge clk); #1;
            apply(t[i]);
            sb_q.push_back('{$sformatf("simul[%0d]", i), expect_of(t[i])});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (observed() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
            end
        end
        #2 rst = 1'b0;
        sb_q.push_back('{"async_rst_now", {Z, Z, O, O, O, O}});
        #1;
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
        end
        sb_q.push_back('{"async_rst_held", {Z, Z, O, O, O, O}});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.push_back('{"rst_release", {Z, Z, O, O, O, O}});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
        end
        sb_q.push_back('{"redrain", {Z, 10'h001, O, I, O, O}});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (observed() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, observed(), e.v);
        end
    endtask

    initial begin
        rst = 1'b0;
        apply('{Z, Z, Z, Z, O, O, Z, Z, O, O, O, O});
        test_reset();
        test_comb();
        test_penalty();
        test_interrupt();
        test_abort();
        test_drain_break();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
